fan_ctrl_sequencer: RTL and testbench

Central fan control sequencer. It consumes the one-cycle gesture pulses (single/double/long) produced by the per-button press decoders and sequences the fan datapath: speed level, PWM duty, off-timer countdown and breeze modulation. It sits between the button decoders and the PWM/motor and FND/LED display blocks, and owns all fan state.

---
 rtl/fan_ctrl_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_fan_ctrl_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fan_ctrl_sequencer.sv
// Fan control sequencer: gesture pulses -> speed, PWM duty, off-timer and breeze.
// Optional breeze modulation is compiled in with `define FAN_BREEZE_EN.
module fan_ctrl_sequencer #(
   parameter int unsigned TICKS_PER_SEC = 125_000_000,
   parameter int unsigned STEP_SEC      = 3600,
   parameter int unsigned BREEZE_SEC    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spd_single,
   input  logic        spd_long,
   input  logic        tmr_single,
   input  logic        tmr_double,
   input  logic        mode_single,
   output logic [1:0]  fan_speed,
   output logic [7:0]  pwm_duty,
   output logic [1:0]  timer_sel,
   output logic [15:0] remain_sec,
   output logic        breeze_en,
   output logic        expired
);

`ifdef FAN_BREEZE_EN
   localparam bit HAS_BREEZE = 1'b1;
`else
   localparam bit HAS_BREEZE = 1'b0;
`endif

   localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned BW = (BREEZE_SEC > 1) ? $clog2(BREEZE_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST  = PW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] BREEZE_LAST = BW'(BREEZE_SEC - 1);

   localparam logic [1:0] ST_OFF    = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_TIMED  = 2'd2;
   localparam logic [1:0] ST_EXPIRE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    speed_q, speed_d;
   logic [1:0]    sel_q, sel_d;
   logic [15:0]   remain_q, remain_d;
   logic          breeze_q, breeze_d;
   logic          phase_q, phase_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          expired_q, expired_d;
   logic [7:0]    duty_q, duty_d;

   logic       sec_tick;
   logic       ev_long, ev_spd, ev_tdbl, ev_tsgl, ev_mode;
   logic       timer_ev;
   logic       expire_now;
   logic [1:0] sel_n;

   function automatic logic [7:0] duty_map(input logic [1:0] s);
      case (s)
         2'd1:    duty_map = 8'd85;
         2'd2:    duty_map = 8'd170;
         2'd3:    duty_map = 8'd255;
         default: duty_map = 8'd0;
      endcase
   endfunction

   assign sec_tick = (presc_q == PRESC_LAST);

   // Fixed-priority arbitration on the raw pulses; losers are dropped.
   assign ev_long = spd_long;
   assign ev_spd  = spd_single & ~spd_long;
   assign ev_tdbl = tmr_double & ~spd_long & ~spd_single;
   assign ev_tsgl = tmr_single & ~spd_long & ~spd_single & ~tmr_double;
   assign ev_mode = mode_single & ~spd_long & ~spd_single & ~tmr_double & ~tmr_single;

   // Events that rewrite the timer take precedence over a coincident countdown tick.
   assign timer_ev = ev_long
                   | (ev_tdbl && state_q == ST_TIMED)
                   | (ev_tsgl && state_q != ST_OFF);

   assign sel_n = sel_q + 2'd1;

   always_comb begin
      state_d    = state_q;
      speed_d    = speed_q;
      sel_d      = sel_q;
      remain_d   = remain_q;
      breeze_d   = breeze_q;
      phase_d    = phase_q;
      bcnt_d     = bcnt_q;
      expired_d  = 1'b0;
      expire_now = 1'b0;
      presc_d    = sec_tick ? '0 : presc_q + 1'b1;

      if (state_q == ST_EXPIRE) begin
         state_d = ST_OFF;
      end else begin
         if (breeze_q && sec_tick) begin
            if (bcnt_q == BREEZE_LAST) begin
               bcnt_d  = '0;
               phase_d = ~phase_q;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end

         if (state_q == ST_TIMED && sec_tick && !timer_ev) begin
            if (remain_q == 16'd1)
               expire_now = 1'b1;
            else if (remain_q != '0)
               remain_d = remain_q - 1'b1;
         end

         if (expire_now) begin
            state_d   = ST_EXPIRE;
            speed_d   = '0;
            sel_d     = '0;
            remain_d  = '0;
            breeze_d  = 1'b0;
            phase_d   = 1'b0;
            bcnt_d    = '0;
            expired_d = 1'b1;
         end else if (ev_long) begin
            state_d  = ST_OFF;
            speed_d  = '0;
            sel_d    = '0;
            remain_d = '0;
            breeze_d = 1'b0;
            phase_d  = 1'b0;
            bcnt_d   = '0;
         end else if (ev_spd) begin
            if (state_q == ST_OFF) begin
               state_d = ST_RUN;
               speed_d = 2'd1;
            end else begin
               speed_d = (speed_q == 2'd3) ? 2'd1 : speed_q + 2'd1;
            end
         end else if (ev_tdbl) begin
            if (state_q == ST_TIMED) begin
               state_d  = ST_RUN;
               sel_d    = '0;
               remain_d = '0;
            end
         end else if (ev_tsgl) begin
            if (state_q != ST_OFF) begin
               sel_d = sel_n;
               if (sel_n != 2'd0) begin
                  state_d  = ST_TIMED;
                  remain_d = 16'(32'(sel_n) * STEP_SEC);
                  presc_d  = '0;
               end else begin
                  state_d  = ST_RUN;
                  remain_d = '0;
               end
            end
         end else if (ev_mode && HAS_BREEZE && state_q != ST_OFF) begin
            breeze_d = ~breeze_q;
            phase_d  = 1'b0;
            bcnt_d   = '0;
         end
      end

      duty_d = (breeze_d && phase_d) ? (duty_map(speed_d) >> 1) : duty_map(speed_d);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_OFF;
         presc_q   <= '0;
         speed_q   <= '0;
         sel_q     <= '0;
         remain_q  <= '0;
         breeze_q  <= 1'b0;
         phase_q   <= 1'b0;
         bcnt_q    <= '0;
         expired_q <= 1'b0;
         duty_q    <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         speed_q   <= speed_d;
         sel_q     <= sel_d;
         remain_q  <= remain_d;
         breeze_q  <= breeze_d;
         phase_q   <= phase_d;
         bcnt_q    <= bcnt_d;
         expired_q <= expired_d;
         duty_q    <= duty_d;
      end
   end

   assign fan_speed  = speed_q;
   assign pwm_duty   = duty_q;
   assign timer_sel  = sel_q;
   assign remain_sec = remain_q;
   assign breeze_en  = breeze_q;
   assign expired    = expired_q;

endmodule

// File: tb/tb_fan_ctrl_sequencer.sv
// Bench for fan_ctrl_sequencer: directed scenarios plus random pulses against a reference model.
module tb_fan_ctrl_sequencer;

   localparam int TICKS  = 10;
   localparam int STEP   = 5;
   localparam int BREEZE = 2;

`ifdef FAN_BREEZE_EN
   localparam bit HAS_BREEZE = 1'b1;
`else
   localparam bit HAS_BREEZE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        spd_single = 1'b0, spd_long = 1'b0;
   logic        tmr_single = 1'b0, tmr_double = 1'b0, mode_single = 1'b0;
   logic [1:0]  fan_speed, timer_sel;
   logic [7:0]  pwm_duty;
   logic [15:0] remain_sec;
   logic        breeze_en, expired;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain integer rules, one call per clock edge.
   int m_speed, m_sel, m_remain, m_presc, m_ticks_in_phase;
   bit m_on, m_timed, m_expiring, m_breeze, m_phase, m_expired;
   int duty_tab [4] = '{0, 85, 170, 255};

   fan_ctrl_sequencer #(
      .TICKS_PER_SEC(TICKS),
      .STEP_SEC     (STEP),
      .BREEZE_SEC   (BREEZE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .spd_single (spd_single),
      .spd_long   (spd_long),
      .tmr_single (tmr_single),
      .tmr_double (tmr_double),
      .mode_single(mode_single),
      .fan_speed  (fan_speed),
      .pwm_duty   (pwm_duty),
      .timer_sel  (timer_sel),
      .remain_sec (remain_sec),
      .breeze_en  (breeze_en),
      .expired    (expired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_clear();
      m_speed = 0; m_sel = 0; m_remain = 0;
      m_on = 0; m_timed = 0; m_breeze = 0; m_phase = 0; m_ticks_in_phase = 0;
   endfunction

   function automatic void model_step(bit rn, bit sl, bit ss, bit td, bit ts, bit ms);
      int win;
      bit tick;
      bit timer_ev;
      if (!rn) begin
         model_clear();
         m_presc = 0; m_expiring = 0; m_expired = 0;
         return;
      end
      tick = (m_presc == TICKS - 1);
      m_presc = tick ? 0 : m_presc + 1;
      m_expired = 0;
      if (m_expiring) begin
         m_expiring = 0;
         return;
      end
      win = sl ? 1 : ss ? 2 : td ? 3 : ts ? 4 : ms ? 5 : 0;
      timer_ev = (win == 1) || (win == 3 && m_timed) || (win == 4 && m_on);
      if (m_breeze && tick) begin
         m_ticks_in_phase++;
         if (m_ticks_in_phase == BREEZE) begin
            m_ticks_in_phase = 0;
            m_phase = !m_phase;
         end
      end
      if (m_timed && tick && !timer_ev) begin
         if (m_remain == 1) begin
            model_clear();
            m_expiring = 1;
            m_expired = 1;
            return;
         end
         m_remain--;
      end
      case (win)
         1: model_clear();
         2: begin
            if (!m_on) begin m_on = 1; m_speed = 1; end
            else m_speed = (m_speed % 3) + 1;
         end
         3: if (m_timed) begin m_timed = 0; m_sel = 0; m_remain = 0; end
         4: if (m_on) begin
            m_sel = (m_sel + 1) % 4;
            m_remain = m_sel * STEP;
            m_timed = (m_sel != 0);
            if (m_sel != 0) m_presc = 0;
         end
         5: if (m_on && HAS_BREEZE) begin
            m_breeze = !m_breeze; m_phase = 0; m_ticks_in_phase = 0;
         end
         default: ;
      endcase
   endfunction

   function automatic int model_duty();
      return (m_breeze && m_phase) ? duty_tab[m_speed] / 2 : duty_tab[m_speed];
   endfunction

   task automatic step(input bit rn, input bit sl, input bit ss, input bit td, input bit ts, input bit ms);
      reset_n = rn; spd_long = sl; spd_single = ss;
      tmr_double = td; tmr_single = ts; mode_single = ms;
      @(posedge clk);
      model_step(rn, sl, ss, td, ts, ms);
      #1;
      check("fan_speed",  32'(fan_speed),  32'(m_speed));
      check("pwm_duty",   32'(pwm_duty),   32'(model_duty()));
      check("timer_sel",  32'(timer_sel),  32'(m_sel));
      check("remain_sec", 32'(remain_sec), 32'(m_remain));
      check("breeze_en",  32'(breeze_en),  32'(m_breeze));
      check("expired",    32'(expired),    32'(m_expired));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int exp_at;
      int pulses;
      int spd_exp [4] = '{1, 2, 3, 1};
      int sel_exp [4] = '{1, 2, 3, 0};

      // Reset state
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("rst_speed", 32'(fan_speed), 0);
      check("rst_duty",  32'(pwm_duty), 0);

      // Speed cycling and long-press off
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 1, 0, 0, 0);
         check("cyc_speed", 32'(fan_speed), 32'(spd_exp[i]));
         check("cyc_duty",  32'(pwm_duty),  32'(duty_tab[spd_exp[i]]));
      end
      step(1, 1, 0, 0, 0, 0);
      check("long_speed", 32'(fan_speed), 0);
      check("long_duty",  32'(pwm_duty), 0);

      // Timer expiry from speed 2
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      check("load_sel",    32'(timer_sel), 2);
      check("load_remain", 32'(remain_sec), 10);
      exp_at = -1;
      pulses = 0;
      for (int k = 1; k <= 150; k++) begin
         step(1, 0, 0, 0, 0, 0);
         if (k == 9)  check("remain_before_tick", 32'(remain_sec), 10);
         if (k == 10) check("remain_first_tick",  32'(remain_sec), 9);
         if (expired === 1'b1) begin
            pulses++;
            if (exp_at < 0) exp_at = k;
         end
      end
      check("expire_cycle",  32'(exp_at), 100);
      check("expire_pulses", 32'(pulses), 1);
      check("expire_speed",  32'(fan_speed), 0);

      // Timer wrap, then cancel by double tap
      step(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 1, 0);
         check("wrap_sel",    32'(timer_sel),  32'(sel_exp[i]));
         check("wrap_remain", 32'(remain_sec), 32'(sel_exp[i] * STEP));
      end
      step(1, 0, 0, 0, 1, 0);
      idle(3);
      step(1, 0, 0, 1, 0, 0);
      check("cancel_remain", 32'(remain_sec), 0);
      check("cancel_sel",    32'(timer_sel), 0);

      // Priority: long + single + timer while at speed 3
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      check("prio_pre_speed", 32'(fan_speed), 3);
      step(1, 1, 1, 0, 1, 0);
      check("prio_speed", 32'(fan_speed), 0);
      check("prio_sel",   32'(timer_sel), 0);

      // Reset mid-countdown, then restart
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      idle(13);
      step(0, 0, 0, 0, 0, 0);
      check("midrst_remain", 32'(remain_sec), 0);
      check("midrst_speed",  32'(fan_speed), 0);
      step(1, 0, 1, 0, 0, 0);
      check("restart_speed", 32'(fan_speed), 1);
      check("restart_duty",  32'(pwm_duty), 85);

      // Breeze at speed 3
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      check("breeze_on",   32'(breeze_en), 32'(HAS_BREEZE));
      check("breeze_duty", 32'(pwm_duty), 255);
      idle(90);

      // Random pulses with occasional reset
      for (int i = 0; i < 3000; i++)
         step($urandom_range(199) != 0,
              $urandom_range(79) == 0, $urandom_range(19) == 0,
              $urandom_range(39) == 0, $urandom_range(29) == 0,
              $urandom_range(19) == 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
